// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arb_stat_cnt.sv
// 32-bit saturating event counter with synchronous active-low clear.
module mem_arb_stat_cnt (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != 32'hFFFF_FFFF)) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM requesters onto one shared variable-latency memory port.
// Define MEM_PORT_ARBITER_STATS_EN to add per-requester stall-cycle counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0]       if_stall_cnt_o,
  output logic [31:0]       dm_stall_cnt_o
`endif
);

  localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  state_t            r_state;
  logic              r_owner;
  logic [CNT_W-1:0]  r_starve;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_ack;
  logic              r_dm_ack;

  logic              w_grant_dm;
  logic              w_grant_if;
  logic              w_if_stall;
  logic              w_dm_stall;

  // DM wins unless IF has already lost STARVE_LIMIT arbitrations in a row.
  assign w_grant_dm = dm_req_i && !(if_req_i && (r_starve == STARVE_MAX));
  assign w_grant_if = if_req_i && !w_grant_dm;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_starve    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_state     <= BUSY_DM;
            r_owner     <= OWN_DM;
            r_mem_req   <= 1'b1;
            r_mem_we    <= dm_we_i;
            r_mem_addr  <= dm_addr_i;
            r_mem_wdata <= dm_wdata_i;
            if (if_req_i && (r_starve != STARVE_MAX)) begin
              r_starve <= r_starve + CNT_W'(1);
            end
          end else if (w_grant_if) begin
            r_state     <= BUSY_IF;
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr_i;
            r_mem_wdata <= '0;
            r_starve    <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (mem_ack_i) begin
            r_mem_req <= 1'b0;
            r_state   <= DONE;
            if (r_owner == OWN_DM) begin
              r_dm_rdata <= mem_rdata_i;
              r_dm_ack   <= 1'b1;
            end else begin
              r_if_rdata <= mem_rdata_i;
              r_if_ack   <= 1'b1;
            end
          end
        end
        // No arbitration here: the finished requester still shows its old request.
        DONE: begin
          r_if_ack <= 1'b0;
          r_dm_ack <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_if_stall  = if_req_i & ~r_if_ack;
  assign w_dm_stall  = dm_req_i & ~r_dm_ack;

  assign if_stall_o  = w_if_stall;
  assign dm_stall_o  = w_dm_stall;
  assign if_ack_o    = r_if_ack;
  assign dm_ack_o    = r_dm_ack;
  assign if_rdata_o  = r_if_rdata;
  assign dm_rdata_o  = r_dm_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

`ifdef MEM_PORT_ARBITER_STATS_EN
  mem_arb_stat_cnt u_if_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_if_stall),
    .cnt_o   (if_stall_cnt_o)
  );

  mem_arb_stat_cnt u_dm_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (w_dm_stall),
    .cnt_o   (dm_stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed preamble, randomized traffic,
// starvation pressure and a mid-transfer reset, all against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmTxn_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        if_stall_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] ifStallCnt;
  logic [31:0] dmStallCnt;
`endif

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .if_stall_o  (if_stall_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_ack_o    (dm_ack_o),
    .dm_stall_o  (dm_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    .if_stall_cnt_o (ifStallCnt),
    .dm_stall_cnt_o (dmStallCnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;
  int cyc;

  // Requester state: each side holds one outstanding request at a time.
  logic        ifPending, dmPending;
  logic [31:0] ifAddr;
  logic        dmWe;
  logic [31:0] dmAddr, dmWdata;
  int          ifAckCycle, dmAckCycle;
  logic [31:0] ifQ[$];
  dmTxn_t      dmQ[$];
  int          latQ[$];
  logic        randomMode;
  int          ifProb, dmProb;

  // Transaction-level model: current access and the cycle it completes.
  logic        recValid, recDm, recWe;
  logic [31:0] recAddr, recWdata, recData;
  int          recG, recK;
  int          idleCycle;
  int          starve;
  logic [31:0] memModel[logic [31:0]];

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memModel.exists(a)) return memModel[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
    end
  endtask

  task automatic resetModel();
    cyc        = 0;
    idleCycle  = 0;
    recValid   = 1'b0;
    recDm      = 1'b0;
    recWe      = 1'b0;
    recG       = -10;
    recK       = -10;
    starve     = 0;
    ifPending  = 1'b0;
    dmPending  = 1'b0;
    ifAckCycle = -10;
    dmAckCycle = -10;
  endtask

  task automatic pushDm(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dmTxn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    dmQ.push_back(t);
  endtask

  // Update requesters, let the model arbitrate, and play the memory for this cycle.
  task automatic applyStimulus();
    dmTxn_t t;
    int     lat;
    logic   grantDm;
    if (ifPending && cyc == ifAckCycle + 1) ifPending = 1'b0;
    if (dmPending && cyc == dmAckCycle + 1) dmPending = 1'b0;
    if (!ifPending) begin
      if (ifQ.size() > 0) begin
        ifAddr = ifQ.pop_front(); ifPending = 1'b1;
      end else if (randomMode && $urandom_range(99) < ifProb) begin
        ifAddr = 32'h1000 + 32'($urandom_range(63)) * 4; ifPending = 1'b1;
      end
    end
    if (!dmPending) begin
      if (dmQ.size() > 0) begin
        t = dmQ.pop_front();
        dmWe = t.we; dmAddr = t.addr; dmWdata = t.wdata; dmPending = 1'b1;
      end else if (randomMode && $urandom_range(99) < dmProb) begin
        dmWe = 1'($urandom_range(1)); dmAddr = 32'($urandom_range(63)) * 4;
        dmWdata = $urandom; dmPending = 1'b1;
      end
    end
    if_req_i   = ifPending;
    if_addr_i  = ifAddr;
    dm_req_i   = dmPending;
    dm_we_i    = dmWe;
    dm_addr_i  = dmAddr;
    dm_wdata_i = dmWdata;

    if (cyc == idleCycle) begin
      if (dmPending || ifPending) begin
        grantDm  = dmPending && !(ifPending && starve == STARVE_LIMIT);
        lat      = (latQ.size() > 0) ? latQ.pop_front() : int'($urandom_range(3));
        recValid = 1'b1;
        recG     = cyc;
        recK     = cyc + 1 + lat;
        idleCycle = recK + 2;
        if (grantDm) begin
          recDm = 1'b1; recWe = dmWe; recAddr = dmAddr; recWdata = dmWdata;
          if (dmWe) memModel[dmAddr] = dmWdata;
          else      recData = memRead(dmAddr);
          dmAckCycle = recK + 1;
          if (ifPending && starve < STARVE_LIMIT) starve++;
        end else begin
          recDm = 1'b0; recWe = 1'b0; recAddr = ifAddr; recWdata = '0;
          recData = memRead(ifAddr);
          ifAckCycle = recK + 1;
          starve = 0;
        end
      end else begin
        idleCycle = cyc + 1;
      end
    end

    mem_ack_i   = recValid && (cyc == recK);
    mem_rdata_i = (mem_ack_i && !recWe) ? recData : $urandom;
  endtask

  task automatic checkCycle();
    logic expReq, expIfAck, expDmAck;
    expReq   = recValid && (cyc > recG) && (cyc <= recK);
    expIfAck = recValid && !recDm && (cyc == recK + 1);
    expDmAck = recValid &&  recDm && (cyc == recK + 1);
    checkOutput("mem_req", 32'(mem_req_o), 32'(expReq));
    if (expReq) begin
      checkOutput("mem_we", 32'(mem_we_o), 32'(recWe));
      checkOutput("mem_addr", mem_addr_o, recAddr);
      if (recWe) checkOutput("mem_wdata", mem_wdata_o, recWdata);
    end
    checkOutput("if_ack", 32'(if_ack_o), 32'(expIfAck));
    checkOutput("dm_ack", 32'(dm_ack_o), 32'(expDmAck));
    if (expIfAck) checkOutput("if_rdata", if_rdata_o, recData);
    if (expDmAck && !recWe) checkOutput("dm_rdata", dm_rdata_o, recData);
    checkOutput("if_stall", 32'(if_stall_o), 32'(if_req_i & ~expIfAck));
    checkOutput("dm_stall", 32'(dm_stall_o), 32'(dm_req_i & ~expDmAck));
  endtask

  task automatic runCycle();
    applyStimulus();
    #1;
    checkCycle();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic drain(input int limit);
    int   n = 0;
    logic timedOut;
    while ((ifPending || dmPending || cyc < idleCycle || ifQ.size() > 0 || dmQ.size() > 0) && n < limit) begin
      runCycle();
      n++;
    end
    timedOut = (n >= limit);
    checkOutput("drain_timeout", 32'(timedOut), 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    if_req_i = 1'b0; if_addr_i = '0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    dm_addr_i = '0; dm_wdata_i = '0;
    ifAddr = '0; dmWe = 1'b0; dmAddr = '0; dmWdata = '0;
    recAddr = '0; recWdata = '0; recData = '0;
    randomMode = 1'b0; ifProb = 0; dmProb = 0;
    resetModel();

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_mem_req",   32'(mem_req_o), 32'd0);
    checkOutput("rst_mem_we",    32'(mem_we_o),  32'd0);
    checkOutput("rst_mem_addr",  mem_addr_o,     32'd0);
    checkOutput("rst_mem_wdata", mem_wdata_o,    32'd0);
    checkOutput("rst_if_ack",    32'(if_ack_o),  32'd0);
    checkOutput("rst_dm_ack",    32'(dm_ack_o),  32'd0);
    checkOutput("rst_if_rdata",  if_rdata_o,     32'd0);
    checkOutput("rst_dm_rdata",  dm_rdata_o,     32'd0);
    rst_n_i = 1'b1;
    resetModel();

    // IF-only read, memory acks two cycles after mem_req_o rises.
    memModel[32'h10] = 32'hDEADBEEF;
    ifQ.push_back(32'h10);
    latQ.push_back(2);
    repeat (5) runCycle();
`ifdef MEM_PORT_ARBITER_STATS_EN
    checkOutput("if_stall_cnt", ifStallCnt, 32'd4);
    checkOutput("dm_stall_cnt", dmStallCnt, 32'd0);
`endif
    drain(50);

    // DM write then read-back of the same word.
    pushDm(1'b1, 32'h04, 32'h0000_0005);
    pushDm(1'b0, 32'h04, 32'h0);
    latQ.push_back(1);
    latQ.push_back(0);
    drain(50);

    // Simultaneous requests: DM first, then IF.
    ifQ.push_back(32'h1010);
    pushDm(1'b0, 32'h08, 32'h0);
    drain(50);

    randomMode = 1'b1; ifProb = 40; dmProb = 40;
    repeat (400) runCycle();
    ifProb = 100; dmProb = 100;
    repeat (300) runCycle();
    randomMode = 1'b0;
    drain(100);

    // Reset while DM owns the memory, then a late mem_ack_i must be ignored.
    pushDm(1'b0, 32'h20, 32'h0);
    latQ.push_back(5);
    repeat (2) runCycle();
    checkOutput("pre_rst_mem_req", 32'(mem_req_o), 32'd1);
    dm_req_i = 1'b0; if_req_i = 1'b0; mem_ack_i = 1'b0;
    rst_n_i  = 1'b0;
    @(posedge clk_i); #1;
    checkOutput("mid_rst_mem_req", 32'(mem_req_o), 32'd0);
    rst_n_i = 1'b1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    checkOutput("late_ack_dm_ack",  32'(dm_ack_o),  32'd0);
    checkOutput("late_ack_mem_req", 32'(mem_req_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("late_ack_dm_ack2", 32'(dm_ack_o),  32'd0);
    checkOutput("late_ack_dm_rdat", dm_rdata_o,     32'd0);
    resetModel();
    ifQ.push_back(32'h1040);
    latQ.push_back(0);
    drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the CPU's instruction-fetch (IF) and data-memory (DM) requesters onto one shared, single-ported, variable-latency backing memory.
- Generates per-requester stall signals for the pipeline's hazard/stall logic.
- Sits between the IF/MEM stages and the off-chip memory model.
- DM normally has priority; a starvation limit guarantees IF progress.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which IF wins over DM; must be >= 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset: synchronous, active-low.
- if_req_i  in  1  IF read request; held stable until if_ack_o.
- if_addr_i  in  ADDR_W  IF read address.
- if_rdata_o  out  DATA_W  IF read data; valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle completion pulse for IF.
- if_stall_o  out  1  if_req_i & ~if_ack_o (combinational).
- dm_req_i  in  1  DM request; held stable until dm_ack_o.
- dm_we_i  in  1  DM write enable (1 = write).
- dm_addr_i  in  ADDR_W  DM address.
- dm_wdata_i  in  DATA_W  DM write data.
- dm_rdata_o  out  DATA_W  DM read data; valid while dm_ack_o=1 and the access was a read.
- dm_ack_o  out  1  one-cycle completion pulse for DM.
- dm_stall_o  out  1  dm_req_i & ~dm_ack_o (combinational).
- mem_req_o  out  1  backing-memory request; held until mem_ack_i.
- mem_we_o  out  1  backing-memory write enable.
- mem_addr_o  out  ADDR_W  backing-memory address.
- mem_wdata_o  out  DATA_W  backing-memory write data.
- mem_rdata_i  in  DATA_W  backing-memory read data, sampled with mem_ack_i.
- mem_ack_i  in  1  backing-memory completion; 1 cycle, any latency >= 0 cycles after mem_req_o rises.

Behaviour:
- Reset (rst_n_i=0 at a clock edge):
  - state=IDLE.
  - All outputs 0: mem_req_o/we/addr/wdata, if/dm_ack_o, if/dm_rdata_o.
  - Starvation counter = 0.
  - Reset mid-transfer abandons it; a later mem_ack_i arriving in IDLE is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE:
  - Arbitration happens only here.
  - Grant DM if dm_req_i and NOT (if_req_i and starve_cnt==STARVE_LIMIT); otherwise grant IF if if_req_i.
  - On grant, register the winner's we/addr/wdata onto mem_*_o, assert mem_req_o, and go to BUSY_x. IF grants always have mem_we_o=0.
  - No request: stay in IDLE.
- BUSY_x:
  - mem_req_o and payload are held constant.
  - On mem_ack_i: register mem_rdata_i into x_rdata_o, drop mem_req_o, assert x_ack_o for exactly one cycle, go to DONE.
- DONE:
  - x_ack_o is high this cycle; the requester still shows its old request.
  - Next state is IDLE; no arbitration in DONE, so a completed request is never regranted.
- Latency: a request seen in IDLE at cycle 0 gives mem_req_o=1 at cycle 1. mem_ack_i at cycle k (k>=1) gives x_ack_o=1 at cycle k+1, and IDLE at cycle k+2. Minimum is 3 cycles per access.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments in IDLE when if_req_i=1 and DM is granted.
  - Clears on any IF grant.
  - Otherwise holds.
- x_rdata_o holds its last value when no ack is pending; rdata after a DM write is don't-care.
- Protocol assumption (no check required): requester inputs change only in the cycle after their ack or while the request is low.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- Defined: adds outputs if_stall_cnt_o[31:0] and dm_stall_cnt_o[31:0].
  - Each counts cycles with the matching x_stall_o=1.
  - Each saturates at 32'hFFFF_FFFF and clears on reset.
  - Benches use these in place of hand-written stall counting.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - the state enum (IDLE/BUSY_IF/BUSY_DM/DONE, 2 bits);
  - default ADDR_W/DATA_W constants;
  - owner encoding (OWN_IF=0, OWN_DM=1).
- Sub-module mem_arb_stat_cnt: 32-bit saturating enable counter with synchronous active-low clear. Instantiated twice, and only under MEM_PORT_ARBITER_STATS_EN.

Test Plan:
- IF-only read: if_req_i=1, addr=0x10; memory acks 2 cycles after mem_req_o with 0xDEADBEEF → if_ack_o pulses 1 cycle at cycle 4 with if_rdata_o=0xDEADBEEF; if_stall_o=1 in cycles 0–3.
- DM write then read: write 0x00000005 to 0x04, then read 0x04 → mem_we_o=1 with wdata=5 for the first access; second access has mem_we_o=0 and dm_rdata_o=5.
- Simultaneous requests: if_req_i=dm_req_i=1 at cycle 0 → DM is granted first (mem_addr_o=dm_addr); IF is granted in the next IDLE; dm_ack_o precedes if_ack_o.
- Starvation, STARVE_LIMIT=4: dm_req_i held asserted with fresh requests while if_req_i=1 → exactly 4 DM grants, then the IF grant; the counter returns to 0.
- Reset mid-transfer: rst_n_i=0 during BUSY_DM, then mem_ack_i arrives after reset release → no dm_ack_o, mem_req_o=0, state=IDLE.
- With MEM_PORT_ARBITER_STATS_EN: IF-only read with ack latency 2 → if_stall_cnt_o=4, dm_stall_cnt_o=0.
